csr_file: RTL and testbench

- Machine-mode CSR register file and trap unit for the single-cycle RV32I core.
- Sits downstream of the main decoder and consumes its csr_rd, csr_wr and is_mret strobes.
- Returns CSR read data to the writeback mux (select 2'b11).
- Samples external and timer interrupt lines and generates the PC redirect for trap entry and MRET.

---
 rtl/csr_pkg.sv | 39 +++
 rtl/csr_file_irq_sync.sv | 31 +++
 rtl/csr_file.sv | 167 ++++++++++++++++
 tb/tb_csr_file.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, bit positions,
// trap cause codes and the CSR read-modify-write operation.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;
   localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MTIE_BIT = 7;
   localparam int MEIE_BIT = 11;

   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                             input logic [31:0] src);
      case (op)
         CSR_RW:  return src;
         CSR_RS:  return old_val | src;
         CSR_RC:  return old_val & ~src;
         default: return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_file_irq_sync.sv
// Parameterised-depth synchroniser for a single level-sensitive interrupt line.
module irq_sync #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sync_q;
   logic [DEPTH-1:0] sync_d;

   always_comb begin
      sync_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and interrupt trap unit for the single-cycle RV32I core.
// Reads are combinational; writes, trap entry and MRET update state on the edge.
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RST    = 32'h0000_0000,
   parameter int          NUM_IRQ_SYNC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] addr,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] pc,
   input  logic        csr_rd,
   input  logic        csr_wr,
   input  logic        is_mret,
   input  logic        ext_irq,
   input  logic        timer_irq,
   output logic [31:0] rdata,
   output logic        epc_taken,
   output logic [31:0] epc,
   output logic        trap_flush
);

   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic        meie_q, meie_d;
   logic        mtie_q, mtie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:2] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d;

   logic        meip, mtip;
   logic [31:0] csr_val;
   logic [31:0] new_val;
   logic [31:0] vec_base;
   logic [3:0]  cause;
   logic        take;
   logic        mret_go;
   logic        wr_en;
   csr_op_e     op;
   logic        unused_ok;

   irq_sync #(.DEPTH(NUM_IRQ_SYNC)) u_ext_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (ext_irq),
      .q     (meip)
   );

   irq_sync #(.DEPTH(NUM_IRQ_SYNC)) u_timer_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (timer_irq),
      .q     (mtip)
   );

   always_comb begin
      csr_val = '0;
      case (addr)
         CSR_MSTATUS: begin
            csr_val[MIE_BIT]  = mie_q;
            csr_val[MPIE_BIT] = mpie_q;
         end
         CSR_MIE: begin
            csr_val[MEIE_BIT] = meie_q;
            csr_val[MTIE_BIT] = mtie_q;
         end
         CSR_MTVEC:   csr_val = mtvec_q;
         CSR_MEPC:    csr_val = {mepc_q, 2'b00};
         CSR_MCAUSE:  csr_val = mcause_q;
         CSR_MIP: begin
            csr_val[MEIE_BIT] = meip;
            csr_val[MTIE_BIT] = mtip;
         end
         CSR_MCYCLE:  csr_val = mcycle_q[31:0];
         CSR_MCYCLEH: csr_val = mcycle_q[63:32];
         default:     csr_val = '0;
      endcase
   end

   // Outputs are gated by reset so no redirect or read data leaks out while held.
   always_comb begin
      take     = rst & mie_q & ((meip & meie_q) | (mtip & mtie_q)) & ~is_mret;
      mret_go  = rst & is_mret;
      cause    = (meip & meie_q) ? CAUSE_MEI : CAUSE_MTI;
      vec_base = {mtvec_q[31:2], 2'b00};
      rdata    = (rst && csr_rd) ? csr_val : '0;
      epc      = '0;
      if (take) begin
         epc = (mtvec_q[1:0] == 2'b01) ? vec_base + {26'd0, cause, 2'b00} : vec_base;
      end else if (mret_go) begin
         epc = {mepc_q, 2'b00};
      end
      epc_taken  = take | mret_go;
      trap_flush = take;
   end

   always_comb begin
      op       = csr_op_e'(funct3[1:0]);
      new_val  = csr_apply(op, csr_val, wdata);
      wr_en    = csr_wr & ~take & (op != CSR_NONE);
      mie_d    = mie_q;
      mpie_d   = mpie_q;
      meie_d   = meie_q;
      mtie_d   = mtie_q;
      mtvec_d  = mtvec_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      mcycle_d = mcycle_q + 64'd1;
      if (wr_en) begin
         case (addr)
            CSR_MSTATUS: begin
               mie_d  = new_val[MIE_BIT];
               mpie_d = new_val[MPIE_BIT];
            end
            CSR_MIE: begin
               meie_d = new_val[MEIE_BIT];
               mtie_d = new_val[MTIE_BIT];
            end
            // Reserved mode encodings 2 and 3 collapse to direct mode.
            CSR_MTVEC:   mtvec_d = {new_val[31:2], new_val[1] ? 2'b00 : new_val[1:0]};
            CSR_MEPC:    mepc_d = new_val[31:2];
            CSR_MCAUSE:  mcause_d = new_val;
            CSR_MCYCLE:  mcycle_d = {mcycle_q[63:32], new_val};
            CSR_MCYCLEH: mcycle_d = {new_val, mcycle_q[31:0]};
            default: ;
         endcase
      end
      if (mret_go) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (take) begin
         mepc_d   = pc[31:2];
         mcause_d = {1'b1, 27'd0, cause};
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         meie_q   <= 1'b0;
         mtie_q   <= 1'b0;
         mtvec_q  <= MTVEC_RST;
         mepc_q   <= '0;
         mcause_q <= '0;
         mcycle_q <= '0;
      end else begin
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
         meie_q   <= meie_d;
         mtie_q   <= mtie_d;
         mtvec_q  <= mtvec_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mcycle_q <= mcycle_d;
      end
   end

   assign unused_ok = ^{funct3[2], pc[1:0]};

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed trap/MRET/mcycle scenarios plus
// randomized traffic checked against a behavioural model of the CSR rules.
module tb_csr_file;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
   localparam int          NSYNC     = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] addr;
   logic [2:0]  funct3;
   logic [31:0] wdata, pc;
   logic        csr_rd, csr_wr, is_mret, ext_irq, timer_irq;
   logic [31:0] rdata, epc;
   logic        epc_taken, trap_flush;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
   logic [63:0] m_mcycle;
   bit          ext_hist[$];
   bit          tim_hist[$];

   logic [65:0] exp_out, act_out;
   logic [31:0] act_rdata, act_epc;
   logic        act_taken, act_flush;

   csr_file #(.MTVEC_RST(MTVEC_RST), .NUM_IRQ_SYNC(NSYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .funct3     (funct3),
      .wdata      (wdata),
      .pc         (pc),
      .csr_rd     (csr_rd),
      .csr_wr     (csr_wr),
      .is_mret    (is_mret),
      .ext_irq    (ext_irq),
      .timer_irq  (timer_irq),
      .rdata      (rdata),
      .epc_taken  (epc_taken),
      .epc        (epc),
      .trap_flush (trap_flush)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] m_mip();
      return (ext_hist[0] ? 32'h800 : 32'h0) | (tim_hist[0] ? 32'h80 : 32'h0);
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_mip();
         12'hB00: return m_mcycle[31:0];
         12'hB80: return m_mcycle[63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_take();
      return (m_mstatus[3] == 1'b1) && ((m_mip() & m_mie) != 0) && !is_mret;
   endfunction

   function automatic logic [3:0] m_cause();
      return ((m_mip() & m_mie & 32'h800) != 0) ? 4'd11 : 4'd7;
   endfunction

   function automatic logic [31:0] m_vector();
      logic [31:0] base;
      base = m_mtvec & ~32'h3;
      return ((m_mtvec & 32'h3) == 1) ? base + 4 * m_cause() : base;
   endfunction

   task automatic m_reset();
      m_mstatus = 0; m_mie = 0; m_mtvec = MTVEC_RST; m_mepc = 0; m_mcause = 0; m_mcycle = 0;
      ext_hist = {}; tim_hist = {};
      for (int i = 0; i < NSYNC; i++) begin
         ext_hist.push_back(1'b0);
         tim_hist.push_back(1'b0);
      end
   endtask

   task automatic m_comb();
      logic [31:0] rd_v;
      rd_v = csr_rd ? m_read(addr) : 32'h0;
      if (!rst)          exp_out = '0;
      else if (m_take()) exp_out = {rd_v, 1'b1, m_vector(), 1'b1};
      else if (is_mret)  exp_out = {rd_v, 1'b1, m_mepc, 1'b0};
      else               exp_out = {rd_v, 1'b0, 32'h0, 1'b0};
   endtask

   task automatic m_edge();
      logic [31:0] old_v, new_v;
      logic [1:0]  mode;
      logic [3:0]  c;
      bit          tk, wrote_cycle;
      if (!rst) begin
         m_reset();
         return;
      end
      tk = m_take();
      c = m_cause();
      wrote_cycle = 0;
      if (csr_wr && !tk && funct3[1:0] != 2'b00) begin
         old_v = m_read(addr);
         case (funct3[1:0])
            2'b01:   new_v = wdata;
            2'b10:   new_v = old_v | wdata;
            default: new_v = old_v & ~wdata;
         endcase
         case (addr)
            12'h300: m_mstatus = new_v & 32'h88;
            12'h304: m_mie = new_v & 32'h880;
            12'h305: begin
               mode = new_v[1:0];
               if (mode > 2'd1) mode = 2'd0;
               m_mtvec = {new_v[31:2], mode};
            end
            12'h341: m_mepc = new_v & ~32'h3;
            12'h342: m_mcause = new_v;
            12'hB00: begin m_mcycle[31:0] = new_v; wrote_cycle = 1; end
            12'hB80: begin m_mcycle[63:32] = new_v; wrote_cycle = 1; end
            default: ;
         endcase
      end
      if (!wrote_cycle) m_mcycle = m_mcycle + 64'd1;
      if (is_mret) begin
         m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (tk) begin
         m_mepc    = pc & ~32'h3;
         m_mcause  = 32'h8000_0000 | {28'd0, c};
         m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end
      ext_hist.push_back(ext_irq);
      void'(ext_hist.pop_front());
      tim_hist.push_back(timer_irq);
      void'(tim_hist.pop_front());
   endtask

   // One instruction: drive, sample outputs mid-cycle, advance model at the edge.
   task automatic cyc(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] p, input logic rd, input logic wr, input logic mret);
      addr = a; funct3 = f3; wdata = wd; pc = p; csr_rd = rd; csr_wr = wr; is_mret = mret;
      @(negedge clk);
      m_comb();
      act_rdata = rdata; act_taken = epc_taken; act_epc = epc; act_flush = trap_flush;
      act_out = {act_rdata, act_taken, act_epc, act_flush};
      $display("txn t=%0t addr=%h f3=%0d wd=%h pc=%h rd=%b wr=%b mret=%b irq=%b%b -> rdata=%h taken=%b epc=%h flush=%b",
               $time, a, f3, wd, p, rd, wr, mret, ext_irq, timer_irq, act_rdata, act_taken, act_epc, act_flush);
      @(posedge clk);
      m_edge();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [11:0] addrs [6];
      logic [31:0] wants [6];
      addrs = '{12'h305, 12'h300, 12'h304, 12'h341, 12'h342, 12'h344};
      wants = '{32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      addr = 12'h305; csr_rd = 1; is_mret = 1; csr_wr = 0; funct3 = 0; wdata = 0; pc = 0;
      @(negedge clk);
      total++;
      if ({rdata, epc_taken, epc, trap_flush} !== 66'd0) begin
         bad++;
         $display("FAIL reset.outputs got rdata=%h taken=%b epc=%h flush=%b want all zero", rdata, epc_taken, epc, trap_flush);
      end
      m_reset();
      @(posedge clk); #1;
      rst = 1;
      for (int i = 0; i < 6; i++) begin
         cyc(addrs[i], 3'b000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
         total++;
         if (act_rdata !== wants[i] || act_out !== exp_out) begin
            bad++;
            $display("FAIL reset.read addr=%h got=%h want=%h", addrs[i], act_rdata, wants[i]);
         end
      end
   endtask

   logic [31:0] trap_pc;

   task automatic test_trap_entry();
      bit found;
      int lat;
      cyc(12'h305, 3'b001, 32'h201, 32'h1000, 1, 1, 0);
      cyc(12'h300, 3'b010, 32'h8, 32'h1004, 1, 1, 0);
      cyc(12'h304, 3'b010, 32'h800, 32'h1008, 1, 1, 0);
      total++;
      if (act_out !== exp_out) begin bad++; $display("FAIL trap_entry.setup got=%h want=%h", act_out, exp_out); end
      ext_irq = 1;
      found = 0; lat = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         cyc(12'h0, 3'b000, 32'h0, 32'h2000 + 4 * i, 0, 0, 0);
         total++;
         if (act_out !== exp_out) begin bad++; $display("FAIL trap_entry.wait got=%h want=%h", act_out, exp_out); end
         if (act_flush === 1'b1) begin found = 1; lat = i; trap_pc = 32'h2000 + 4 * i; end
      end
      total++;
      if (!found || lat != NSYNC || act_epc !== 32'h22C || act_taken !== 1'b1) begin
         bad++;
         $display("FAIL trap_entry.redirect found=%0d latency=%0d epc=%h want latency=%0d epc=0000022c", found, lat, act_epc, NSYNC);
      end
      cyc(12'h341, 3'b000, 32'h0, 32'h2100, 1, 0, 0);
      total++;
      if (act_rdata !== trap_pc) begin bad++; $display("FAIL trap_entry.mepc got=%h want=%h", act_rdata, trap_pc); end
      cyc(12'h342, 3'b000, 32'h0, 32'h2104, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h8000_000B) begin bad++; $display("FAIL trap_entry.mcause got=%h want=8000000b", act_rdata); end
      cyc(12'h300, 3'b000, 32'h0, 32'h2108, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h80) begin bad++; $display("FAIL trap_entry.mstatus got=%h want=00000080", act_rdata); end
   endtask

   task automatic test_priority();
      timer_irq = 1;
      cyc(12'h304, 3'b010, 32'h80, 32'h3000, 1, 1, 0);
      repeat (NSYNC) cyc(12'h0, 3'b000, 32'h0, 32'h3004, 0, 0, 0);
      cyc(12'h0, 3'b000, 32'h0, 32'h3008, 0, 0, 1);
      total++;
      if (act_out !== exp_out || act_epc !== trap_pc || act_flush !== 1'b0) begin
         bad++; $display("FAIL priority.mret1 got=%h want=%h", act_out, exp_out);
      end
      cyc(12'h0, 3'b000, 32'h0, 32'h3100, 0, 0, 0);
      total++;
      if (act_out !== exp_out || act_epc !== 32'h22C || act_flush !== 1'b1) begin
         bad++; $display("FAIL priority.both got epc=%h flush=%b want epc=0000022c flush=1", act_epc, act_flush);
      end
      ext_irq = 0;
      repeat (NSYNC) cyc(12'h0, 3'b000, 32'h0, 32'h3104, 0, 0, 0);
      cyc(12'h0, 3'b000, 32'h0, 32'h3108, 0, 0, 1);
      total++;
      if (act_epc !== 32'h3100 || act_flush !== 1'b0) begin
         bad++; $display("FAIL priority.mret2 got epc=%h flush=%b want epc=00003100 flush=0", act_epc, act_flush);
      end
      cyc(12'h0, 3'b000, 32'h0, 32'h3200, 0, 0, 0);
      total++;
      if (act_out !== exp_out || act_epc !== 32'h21C || act_flush !== 1'b1) begin
         bad++; $display("FAIL priority.timer got epc=%h flush=%b want epc=0000021c flush=1", act_epc, act_flush);
      end
      cyc(12'h342, 3'b000, 32'h0, 32'h3204, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h8000_0007) begin bad++; $display("FAIL priority.mcause got=%h want=80000007", act_rdata); end
   endtask

   task automatic test_mret_priority();
      cyc(12'h341, 3'b001, 32'h400, 32'h4000, 1, 1, 0);
      cyc(12'h0, 3'b000, 32'h0, 32'h500, 0, 0, 1);
      total++;
      if (act_out !== exp_out || act_epc !== 32'h400 || act_flush !== 1'b0) begin
         bad++; $display("FAIL mret_priority.mret got epc=%h flush=%b want epc=00000400 flush=0", act_epc, act_flush);
      end
      cyc(12'h0, 3'b000, 32'h0, 32'h400, 0, 0, 1);
      total++;
      if (act_out !== exp_out || act_epc !== 32'h400 || act_flush !== 1'b0 || act_taken !== 1'b1) begin
         bad++; $display("FAIL mret_priority.over_irq got epc=%h flush=%b want epc=00000400 flush=0", act_epc, act_flush);
      end
      cyc(12'h0, 3'b000, 32'h0, 32'h400, 0, 0, 0);
      total++;
      if (act_out !== exp_out || act_flush !== 1'b1 || act_epc !== 32'h21C) begin
         bad++; $display("FAIL mret_priority.trap got epc=%h flush=%b want epc=0000021c flush=1", act_epc, act_flush);
      end
      cyc(12'h341, 3'b000, 32'h0, 32'h4004, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h400) begin bad++; $display("FAIL mret_priority.mepc got=%h want=00000400", act_rdata); end
   endtask

   task automatic test_write_in_trap();
      cyc(12'h0, 3'b000, 32'h0, 32'h600, 0, 0, 1);
      cyc(12'h304, 3'b011, 32'h80, 32'h604, 1, 1, 0);
      total++;
      if (act_out !== exp_out || act_flush !== 1'b1 || act_rdata !== 32'h880) begin
         bad++; $display("FAIL write_in_trap.rc got rdata=%h flush=%b want rdata=00000880 flush=1", act_rdata, act_flush);
      end
      cyc(12'h304, 3'b000, 32'h0, 32'h608, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h880) begin bad++; $display("FAIL write_in_trap.mie got=%h want=00000880", act_rdata); end
      cyc(12'h0, 3'b000, 32'h0, 32'h700, 0, 0, 1);
      cyc(12'h341, 3'b001, 32'h7777_0000, 32'h708, 0, 1, 0);
      cyc(12'h341, 3'b000, 32'h0, 32'h70C, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h708) begin bad++; $display("FAIL write_in_trap.mepc got=%h want=00000708", act_rdata); end
      timer_irq = 0;
      repeat (NSYNC) cyc(12'h0, 3'b000, 32'h0, 32'h710, 0, 0, 0);
   endtask

   task automatic test_mcycle_mip();
      cyc(12'hB00, 3'b001, 32'hFFFF_FFFF, 32'h800, 0, 1, 0);
      cyc(12'hB80, 3'b001, 32'h0, 32'h804, 0, 1, 0);
      cyc(12'hB00, 3'b000, 32'h0, 32'h808, 1, 0, 0);
      total++;
      if (act_out !== exp_out || act_rdata !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL mcycle.hold got=%h want=ffffffff", act_rdata);
      end
      cyc(12'hB80, 3'b000, 32'h0, 32'h80C, 1, 0, 0);
      total++;
      if (act_out !== exp_out || act_rdata !== 32'h1) begin bad++; $display("FAIL mcycle.high got=%h want=00000001", act_rdata); end
      cyc(12'hB00, 3'b000, 32'h0, 32'h810, 1, 0, 0);
      total++;
      if (act_out !== exp_out || act_rdata !== 32'h1) begin bad++; $display("FAIL mcycle.low got=%h want=00000001", act_rdata); end
      cyc(12'h344, 3'b001, 32'hFFFF_FFFF, 32'h814, 1, 1, 0);
      cyc(12'h344, 3'b000, 32'h0, 32'h818, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h0) begin bad++; $display("FAIL mip.readonly got=%h want=00000000", act_rdata); end
      cyc(12'h305, 3'b001, 32'h303, 32'h81C, 0, 1, 0);
      cyc(12'h305, 3'b000, 32'h0, 32'h820, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h300) begin bad++; $display("FAIL mtvec.mode got=%h want=00000300", act_rdata); end
   endtask

   task automatic test_random();
      logic [11:0] addrs [9];
      logic [31:0] wd;
      logic        wr, mret;
      addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80, 12'h123};
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(7) == 0) ext_irq = ~ext_irq;
         if ($urandom_range(7) == 0) timer_irq = ~timer_irq;
         wd = ($urandom_range(1) == 0) ? $urandom() : ($urandom() & 32'h0000_0889);
         wr = 1'($urandom_range(1));
         mret = !wr && ($urandom_range(15) == 0);
         cyc(addrs[$urandom_range(8)], 3'($urandom_range(7)), wd, $urandom() & ~32'h3,
             1'($urandom_range(1)), wr, mret);
         total++;
         if (act_out !== exp_out) begin bad++; $display("FAIL random[%0d] got=%h want=%h", i, act_out, exp_out); end
      end
      ext_irq = 0; timer_irq = 0;
   endtask

   task automatic test_reset_mid_trap();
      ext_irq = 1;
      cyc(12'h304, 3'b010, 32'h800, 32'h900, 0, 1, 0);
      repeat (NSYNC) cyc(12'h0, 3'b000, 32'h0, 32'h904, 0, 0, 0);
      cyc(12'h300, 3'b010, 32'h8, 32'h908, 0, 1, 0);
      addr = 12'h341; funct3 = 0; wdata = 0; pc = 32'h90C; csr_rd = 1; csr_wr = 0; is_mret = 0;
      #1;
      total++;
      if (trap_flush !== 1'b1) begin bad++; $display("FAIL reset_mid.pre got flush=%b want=1", trap_flush); end
      rst = 0;
      #1;
      total++;
      if ({rdata, epc_taken, epc, trap_flush} !== 66'd0) begin
         bad++; $display("FAIL reset_mid.outputs got rdata=%h taken=%b epc=%h flush=%b want all zero", rdata, epc_taken, epc, trap_flush);
      end
      m_reset();
      @(posedge clk); #1;
      rst = 1;
      cyc(12'h341, 3'b000, 32'h0, 32'h910, 1, 0, 0);
      total++;
      if (act_out !== exp_out || act_rdata !== 32'h0 || act_taken !== 1'b0) begin
         bad++; $display("FAIL reset_mid.after got=%h want=%h", act_out, exp_out);
      end
      cyc(12'h305, 3'b000, 32'h0, 32'h914, 1, 0, 0);
      total++;
      if (act_rdata !== 32'h100) begin bad++; $display("FAIL reset_mid.mtvec got=%h want=00000100", act_rdata); end
   endtask

   initial begin
      rst = 0; addr = 0; funct3 = 0; wdata = 0; pc = 0;
      csr_rd = 0; csr_wr = 0; is_mret = 0; ext_irq = 0; timer_irq = 0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_trap_entry();
      test_priority();
      test_mret_priority();
      test_write_in_trap();
      test_mcycle_mip();
      test_random();
      test_reset_mid_trap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before completion");
      $fatal(1, "timeout");
   end

endmodule
